// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
//==============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register for a 5-stage MIPS core.
//               It carries the decoded operands, register addresses and the
//               control bundle from the decode stage into the execute stage.
//               It also provides:
//                 - a valid bit
//                 - stall hold, and flush-to-bubble
//                 - memory of a flush that arrives while stalled
//                 - load-use hazard detection
//                 - a saturating count of inserted bubbles
// Ports       : clk, rst_n            - clock (rising edge), async active-low
//                                       reset
//               id_*                  - decode-stage instruction fields
//               stall, flush          - pipeline control from downstream/branch
//               ex_*                  - registered fields presented to EX
//               hazard_stall          - load-use hazard, freeze PC and IF/ID
//               flush_pending         - flush seen during a stall, not applied
//               bubble_cnt            - saturating count of bubbles inserted
// Revision    : 1.0 - initial release
//==============================================================================
module id_ex_pipe_reg #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int CTRL_W    = 8,
   parameter int MEMRD_BIT = 3,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // decode stage
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_b,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_se,
   input  logic [DATA_W-1:0] id_offset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [CTRL_W-1:0] id_ctrl,
   // pipeline control
   input  logic              stall,
   input  logic              flush,
   // execute stage
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_se,
   output logic [DATA_W-1:0] ex_offset,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   // status
   output logic              hazard_stall,
   output logic              flush_pending,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0]  c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

   // registered stage contents
   logic              valid_q,   valid_d;
   logic [DATA_W-1:0] b_q,       b_d;
   logic [DATA_W-1:0] rd1_q,     rd1_d;
   logic [DATA_W-1:0] rd2_q,     rd2_d;
   logic [DATA_W-1:0] se_q,      se_d;
   logic [DATA_W-1:0] offset_q,  offset_d;
   logic [REG_AW-1:0] rs_q,      rs_d;
   logic [REG_AW-1:0] rt_q,      rt_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
   logic              pend_q,    pend_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;

   logic              w_rs_match;
   logic              w_rt_match;
   logic              w_hazard;
   logic [CNT_W-1:0]  w_cnt_inc;

   //---------------------------------------------------------------------------
   // Load-use hazard: the instruction in EX is a load whose destination (rt)
   // is a source of the instruction in ID. Register 0 is hard-wired to zero,
   // so a load targeting it can never create a real dependency.
   //---------------------------------------------------------------------------
   assign w_rs_match = id_uses_rs & (id_rs == rt_q);
   assign w_rt_match = id_uses_rt & (id_rt == rt_q);
   assign w_hazard   = id_valid & valid_q & ctrl_q[MEMRD_BIT] &
                       (rt_q != c_REG_ZERO) & (w_rs_match | w_rt_match);

   // saturating increment: stick at all-ones instead of wrapping
   assign w_cnt_inc  = (cnt_q == c_CNT_MAX) ? cnt_q : (cnt_q + c_CNT_ONE);

   //---------------------------------------------------------------------------
   // Next-state selection, highest priority first:
   //   stall       -> hold everything, remember a flush for later
   //   flush/pend  -> bubble, pending flush consumed
   //   hazard      -> bubble, ID keeps the same instruction for next cycle
   //   otherwise   -> load ID fields
   //---------------------------------------------------------------------------
   always_comb begin
      valid_d  = valid_q;
      b_d      = b_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      se_d     = se_q;
      offset_d = offset_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      ctrl_d   = ctrl_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;

      if (stall) begin
         if (flush) begin
            pend_d = 1'b1;
         end
      end else if (flush || pend_q || w_hazard) begin
         // A bubble clears every field, so no stale write-enable or operand
         // survives into later stages. Flush and hazard together still give a
         // single bubble.
         valid_d  = 1'b0;
         b_d      = '0;
         rd1_d    = '0;
         rd2_d    = '0;
         se_d     = '0;
         offset_d = '0;
         rs_d     = '0;
         rt_d     = '0;
         rd_d     = '0;
         ctrl_d   = '0;
         pend_d   = 1'b0;
         cnt_d    = w_cnt_inc;
      end else begin
         valid_d  = id_valid;
         b_d      = id_b;
         rd1_d    = id_rd1;
         rd2_d    = id_rd2;
         se_d     = id_se;
         offset_d = id_offset;
         rs_d     = id_rs;
         rt_d     = id_rt;
         rd_d     = id_rd;
         ctrl_d   = id_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         b_q      <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         se_q     <= '0;
         offset_q <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         ctrl_q   <= '0;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         b_q      <= b_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         se_q     <= se_d;
         offset_q <= offset_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         ctrl_q   <= ctrl_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_b          = b_q;
   assign ex_rd1        = rd1_q;
   assign ex_rd2        = rd2_q;
   assign ex_se         = se_q;
   assign ex_offset     = offset_q;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_rd         = rd_q;
   assign ex_ctrl       = ctrl_q;
   assign hazard_stall  = w_hazard;
   assign flush_pending = pend_q;
   assign bubble_cnt    = cnt_q;

endmodule
`default_nettype wire
